// File: rtl/bus_read_collector.sv
// bus_read_collector: sequences one read at a time to all read-mapped slaves and
// collects the first select/data reply, falling back to open-bus fill on timeout.
module bus_read_collector #(
   parameter int NUM_DEV = 4,
   parameter int RESP_WAIT = 2,
   parameter logic [7:0] OPEN_BUS = 8'hFF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [19:0]          req_addr,
   output logic [19:0]          addr,
   output logic                 rd,
   input  logic [NUM_DEV-1:0]   sel,
   input  logic [8*NUM_DEV-1:0] data,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [7:0]           rsp_data,
   output logic                 rsp_hit,
   output logic                 conflict
);
   localparam int CW = $clog2(RESP_WAIT + 1);
   typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT, S_RESP} state_t;
   state_t state, nxt;
   logic [CW-1:0] cnt;
   logic [7:0] pick;
   logic hit, multi, timeout;
   assign hit = |sel;
   assign multi = |(sel & (sel - NUM_DEV'(1)));
   assign timeout = cnt == CW'(RESP_WAIT - 1);
   // Lowest-index asserted slave wins.
   always_comb begin
      pick = OPEN_BUS;
      for (int k = NUM_DEV - 1; k >= 0; k--) if (sel[k]) pick = data[8*k +: 8];
   end
   always_ff @(posedge clk)
      if (rst) state <= S_IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state == S_IDLE   ? (req_valid ? S_STROBE : S_IDLE) :
            state == S_STROBE ? S_WAIT :
            state == S_WAIT   ? ((hit || timeout) ? S_RESP : S_WAIT) :
                                (rsp_ready ? S_IDLE : S_RESP);
   end
   always_comb begin
      req_ready = state == S_IDLE && !rst;
      rd = state == S_STROBE;
      rsp_valid = state == S_RESP;
   end
   // Replies are only looked at in WAIT; stale selects elsewhere are ignored.
   always_ff @(posedge clk)
      if (rst) begin
         addr <= '0;
         cnt <= '0;
         rsp_data <= '0;
         rsp_hit <= 1'b0;
         conflict <= 1'b0;
      end else begin
         if (state == S_IDLE && req_valid) addr <= req_addr;
         if (state == S_STROBE) cnt <= '0;
         if (state == S_WAIT) begin
            cnt <= cnt + CW'(1);
            if (hit) begin
               rsp_data <= pick;
               rsp_hit <= 1'b1;
               if (multi) conflict <= 1'b1;
            end else if (timeout) begin
               rsp_data <= OPEN_BUS;
               rsp_hit <= 1'b0;
            end
         end
      end
endmodule

// File: tb/tb_bus_read_collector.sv
// tb_bus_read_collector: directed scenarios for the read collector with hand-computed expectations.
module tb_bus_read_collector;
   logic clk = 0, rst = 1, req_valid = 0, rsp_ready = 0;
   logic [19:0] req_addr = 0;
   logic [3:0] sel = 0;
   logic [31:0] data = 0;
   logic req_ready, rd, rsp_valid, rsp_hit, conflict;
   logic [19:0] addr;
   logic [7:0] rsp_data;
   int total = 0, bad = 0;
   bus_read_collector #(.NUM_DEV(4), .RESP_WAIT(2), .OPEN_BUS(8'hFF)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .addr(addr), .rd(rd), .sel(sel), .data(data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_hit(rsp_hit), .conflict(conflict));
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   // Accept a request from IDLE, leaving the bench in the STROBE cycle.
   task automatic issue(input logic [19:0] a);
      req_valid = 1; req_addr = a;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL issue_ready got=%b exp=1", req_ready); end
      tick();
      req_valid = 0;
      total++; if (rd !== 1'b1) begin bad++; $display("FAIL issue_rd got=%b exp=1", rd); end
      total++; if (addr !== a) begin bad++; $display("FAIL issue_addr got=%h exp=%h", addr, a); end
   endtask
   task automatic finish_rsp();
      rsp_ready = 1;
      tick();
      rsp_ready = 0;
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL release_valid got=%b exp=0", rsp_valid); end
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b exp=1", req_ready); end
   endtask
   task automatic test_reset();
      rst = 1;
      tick(); tick();
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", req_ready); end
      total++; if ({rd, rsp_valid, rsp_hit, conflict} !== 4'b0) begin bad++; $display("FAIL rst_flags got=%b exp=0000", {rd, rsp_valid, rsp_hit, conflict}); end
      total++; if (addr !== 20'h0 || rsp_data !== 8'h00) begin bad++; $display("FAIL rst_regs got=%h/%h exp=0/0", addr, rsp_data); end
      rst = 0;
      #1;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", req_ready); end
   endtask
   task automatic test_rom_hit();
      issue(20'hC8010);
      tick();
      sel = 4'b0100; data = 32'h0055_0000;
      total++; if (rd !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL hit_w0 got=%b%b exp=00", rd, rsp_valid); end
      tick();
      sel = 0; data = 0;
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL hit_valid got=%b exp=1", rsp_valid); end
      total++; if (rsp_data !== 8'h55) begin bad++; $display("FAIL hit_data got=%h exp=55", rsp_data); end
      total++; if (rsp_hit !== 1'b1 || conflict !== 1'b0) begin bad++; $display("FAIL hit_flags got=%b%b exp=10", rsp_hit, conflict); end
      finish_rsp();
   endtask
   task automatic test_unmapped();
      data = 32'h1234_5678;
      issue(20'hD0000);
      tick();
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL unm_w0 got=%b exp=0", rsp_valid); end
      tick();
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL unm_w1 got=%b exp=0", rsp_valid); end
      tick();
      data = 0;
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL unm_valid got=%b exp=1", rsp_valid); end
      total++; if (rsp_data !== 8'hFF || rsp_hit !== 1'b0) begin bad++; $display("FAIL unm_data got=%h/%b exp=ff/0", rsp_data, rsp_hit); end
      finish_rsp();
   endtask
   task automatic test_late_hit();
      issue(20'hE0004);
      tick();
      tick();
      sel = 4'b0010; data = 32'h0000_C300;
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL late_w1 got=%b exp=0", rsp_valid); end
      tick();
      sel = 0; data = 0;
      total++; if (rsp_valid !== 1'b1 || rsp_data !== 8'hC3 || rsp_hit !== 1'b1) begin bad++; $display("FAIL late_rsp got=%b/%h/%b exp=1/c3/1", rsp_valid, rsp_data, rsp_hit); end
      finish_rsp();
   endtask
   task automatic test_conflict();
      issue(20'hC0000);
      tick();
      sel = 4'b1010; data = 32'h3300_1100;
      tick();
      sel = 0; data = 0;
      total++; if (rsp_data !== 8'h11 || rsp_hit !== 1'b1) begin bad++; $display("FAIL conf_data got=%h/%b exp=11/1", rsp_data, rsp_hit); end
      total++; if (conflict !== 1'b1) begin bad++; $display("FAIL conf_flag got=%b exp=1", conflict); end
      finish_rsp();
      issue(20'hC0100);
      tick();
      sel = 4'b0001; data = 32'h0000_0077;
      tick();
      sel = 0; data = 0;
      total++; if (rsp_data !== 8'h77) begin bad++; $display("FAIL conf_clean_data got=%h exp=77", rsp_data); end
      total++; if (conflict !== 1'b1) begin bad++; $display("FAIL conf_sticky got=%b exp=1", conflict); end
      finish_rsp();
   endtask
   task automatic test_backpressure();
      issue(20'hF0000);
      tick();
      sel = 4'b0001; data = 32'h0000_00AB;
      tick();
      sel = 0; data = 0;
      req_valid = 1; req_addr = 20'h12345;
      for (int i = 0; i < 5; i++) begin
         total++; if (rsp_valid !== 1'b1 || rsp_data !== 8'hAB) begin bad++; $display("FAIL bp_hold%0d got=%b/%h exp=1/ab", i, rsp_valid, rsp_data); end
         total++; if (req_ready !== 1'b0 || rd !== 1'b0) begin bad++; $display("FAIL bp_quiet%0d got=%b%b exp=00", i, req_ready, rd); end
         tick();
      end
      req_valid = 0;
      total++; if (addr !== 20'hF0000) begin bad++; $display("FAIL bp_addr got=%h exp=f0000", addr); end
      finish_rsp();
      tick();
      total++; if (rd !== 1'b0) begin bad++; $display("FAIL bp_no_rd got=%b exp=0", rd); end
   endtask
   task automatic test_stale_sel();
      sel = 4'b1111; data = 32'hAAAA_AAAA;
      tick();
      issue(20'hA5000);
      tick();
      sel = 0; data = 0;
      tick();
      tick();
      total++; if (rsp_valid !== 1'b1 || rsp_data !== 8'hFF || rsp_hit !== 1'b0) begin bad++; $display("FAIL stale_rsp got=%b/%h/%b exp=1/ff/0", rsp_valid, rsp_data, rsp_hit); end
      finish_rsp();
   endtask
   task automatic test_reset_in_wait();
      issue(20'hB0000);
      tick();
      rst = 1;
      tick();
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rw_ready_in_rst got=%b exp=0", req_ready); end
      rst = 0;
      sel = 4'b0001; data = 32'h0000_0099;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (rsp_valid !== 1'b0 || rd !== 1'b0) begin bad++; $display("FAIL rw_quiet%0d got=%b%b exp=00", i, rsp_valid, rd); end
         tick();
      end
      sel = 0; data = 0;
      total++; if ({rsp_hit, conflict} !== 2'b00 || addr !== 20'h0 || rsp_data !== 8'h00) begin bad++; $display("FAIL rw_regs got=%b%b/%h/%h exp=00/0/0", rsp_hit, conflict, addr, rsp_data); end
      issue(20'hB1234);
      tick();
      sel = 4'b1000; data = 32'h5A00_0000;
      tick();
      sel = 0; data = 0;
      total++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h5A || rsp_hit !== 1'b1) begin bad++; $display("FAIL rw_next got=%b/%h/%b exp=1/5a/1", rsp_valid, rsp_data, rsp_hit); end
      finish_rsp();
   endtask
   initial begin
      #1;
      test_reset();
      test_rom_hit();
      test_unmapped();
      test_late_hit();
      test_conflict();
      test_backpressure();
      test_stale_sel();
      test_reset_in_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
